brid_alloc: RTL and testbench

- Allocates branch IDs (brid) to decoded control-flow instructions: branch, jal and jalr.
- Releases brids in order at commit, and rolls back allocation on a redirect or a full flush.
- Sits between the decoder and the rename stage. It fills the brid field of the decode bundle and the ROB decode record.
- Maintains a circular ID window with a head pointer (oldest in flight) and a tail pointer (next to allocate), each carrying one extra wrap bit.

---
 rtl/brid_alloc_pkg.sv | 23 ++
 rtl/id_ring_ptr.sv | 36 +++
 rtl/brid_alloc.sv | 142 ++++++++++++++
 tb/tb_brid_alloc.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/brid_alloc_pkg.sv
// Shared types and helpers for the branch-ID allocator and sibling ID allocators.
package brid_alloc_pkg;

    localparam int unsigned BRID_W = 7;

    // MSB is the valid flag; [BRID_W-1:0] is the ID.
    typedef logic [BRID_W:0] brid_t;

    // True when id lies in [head, tail) of a ring whose index mask is idx_mask (DEPTH-1).
    // head/tail carry the wrap bit just above the index bits.
    function automatic logic brid_in_window(input logic [7:0] head, input logic [7:0] tail,
                                            input logic [BRID_W-1:0] id,
                                            input logic [7:0] idx_mask);
        logic [7:0] ptr_mask;
        logic [7:0] offset;
        logic [7:0] used;
        ptr_mask = {idx_mask[6:0], 1'b1};
        offset   = ({1'b0, id} - head) & idx_mask;
        used     = (tail - head) & ptr_mask;
        return ((({1'b0, id}) & ~idx_mask) == 8'd0) && (offset < used);
    endfunction

endpackage

// File: rtl/id_ring_ptr.sv
// Ring pointer with an extra wrap bit; supports add-n and direct set (set wins).
module id_ring_ptr #(
    parameter int unsigned PTRW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            add_en_i,
    input  logic [PTRW-1:0] add_n_i,
    input  logic            set_en_i,
    input  logic [PTRW-1:0] set_val_i,
    output logic [PTRW-1:0] ptr_o
);

    logic [PTRW-1:0] ptr_d;
    logic [PTRW-1:0] ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (set_en_i) begin
            ptr_d = set_val_i;
        end else if (add_en_i) begin
            ptr_d = ptr_q + add_n_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/brid_alloc.sv
// Branch-ID allocator: in-order allocate at decode, in-order release at commit,
// rollback on redirect or flush.
module brid_alloc
    import brid_alloc_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DECW  = 2,
    parameter int unsigned COMW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DECW-1:0]      dec_valid,
    input  logic [DECW-1:0]      dec_br,
    output logic                 dec_ready,
    output brid_t [DECW-1:0]     dec_brid,
    input  logic [COMW-1:0]      com_valid,
    input  brid_t [COMW-1:0]     com_brid,
    input  logic                 redir_valid,
    input  brid_t                redir_brid,
    input  logic                 flush,
    output logic [7:0]           free_cnt,
    output logic [7:0]           inflight,
    output logic                 err
);

    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned PTRW = PW + 1;

    logic [PTRW-1:0] head_q;
    logic [PTRW-1:0] tail_q;
    logic [PTRW-1:0] used_ptr;
    logic [DECW-1:0] req;
    logic [7:0]      need;
    logic [PW-1:0]   slot_idx;
    logic [7:0]      cnt;
    logic [PW-1:0]   expect_idx;
    logic            com_bad;
    logic            com_over;
    logic [PW-1:0]   redir_off;
    logic [PTRW-1:0] redir_tail;
    logic [7:0]      redir_len;
    logic            redir_ok;
    logic            redir_take;
    logic            head_set;
    logic [PTRW-1:0] head_set_val;
    logic [PTRW-1:0] head_d;
    logic            tail_set;
    logic [PTRW-1:0] tail_set_val;
    logic            err_d;
    logic            err_q;

    assign used_ptr = tail_q - head_q;
    assign inflight = 8'(used_ptr);
    assign free_cnt = 8'(DEPTH) - inflight;
    assign req      = dec_valid & dec_br;

    always_comb begin
        dec_brid = '0;
        need     = '0;
        slot_idx = '0;
        for (int i = 0; i < DECW; i++) begin
            if (req[i]) begin
                slot_idx    = tail_q[PW-1:0] + need[PW-1:0];
                dec_brid[i] = {1'b1, BRID_W'(slot_idx)};
                need        = need + 8'd1;
            end
        end
        dec_ready = !flush && !redir_valid && (need <= free_cnt);
    end

    // Committed IDs must be consecutive starting at head.
    always_comb begin
        cnt        = '0;
        com_bad    = 1'b0;
        expect_idx = '0;
        for (int i = 0; i < COMW; i++) begin
            if (com_valid[i] && com_brid[i][BRID_W]) begin
                expect_idx = head_q[PW-1:0] + cnt[PW-1:0];
                if (com_brid[i][BRID_W-1:0] != BRID_W'(expect_idx)) begin
                    com_bad = 1'b1;
                end
                cnt = cnt + 8'd1;
            end
        end
        com_over = cnt > inflight;
    end

    always_comb begin
        redir_off  = redir_brid[PW-1:0] - head_q[PW-1:0];
        redir_tail = head_q + PTRW'(redir_off) + PTRW'(1);
        redir_len  = 8'(redir_off) + 8'd1;
        redir_ok   = redir_brid[BRID_W] &&
                     brid_in_window(8'(head_q), 8'(tail_q), redir_brid[BRID_W-1:0],
                                    8'(DEPTH - 1));
        redir_take = redir_valid && !flush && redir_ok;

        // Head never passes the post-redirect tail.
        head_set     = com_over || (redir_take && (cnt > redir_len));
        head_set_val = redir_take ? redir_tail : tail_q;
        head_d       = head_set ? head_set_val : head_q + PTRW'(cnt);

        tail_set     = flush || redir_take;
        tail_set_val = flush ? head_d : redir_tail;

        err_d = err_q || com_bad || com_over || (redir_valid && !flush && !redir_ok);
    end

    id_ring_ptr #(
        .PTRW (PTRW)
    ) u_head (
        .clk       (clk),
        .rst_n     (rst_n),
        .add_en_i  (1'b1),
        .add_n_i   (PTRW'(cnt)),
        .set_en_i  (head_set),
        .set_val_i (head_set_val),
        .ptr_o     (head_q)
    );

    id_ring_ptr #(
        .PTRW (PTRW)
    ) u_tail (
        .clk       (clk),
        .rst_n     (rst_n),
        .add_en_i  (dec_ready),
        .add_n_i   (PTRW'(need)),
        .set_en_i  (tail_set),
        .set_val_i (tail_set_val),
        .ptr_o     (tail_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_brid_alloc.sv
// Directed bench for brid_alloc (DEPTH=16, DECW=2, COMW=2) with hand-computed expectations.
module tb_brid_alloc;

    logic            clk;
    logic            rst_n;
    logic [1:0]      dec_valid;
    logic [1:0]      dec_br;
    logic            dec_ready;
    logic [1:0][7:0] dec_brid;
    logic [1:0]      com_valid;
    logic [1:0][7:0] com_brid;
    logic            redir_valid;
    logic [7:0]      redir_brid;
    logic            flush;
    logic [7:0]      free_cnt;
    logic [7:0]      inflight;
    logic            err;

    int total;
    int bad;

    brid_alloc #(
        .DEPTH (16),
        .DECW  (2),
        .COMW  (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dec_valid   (dec_valid),
        .dec_br      (dec_br),
        .dec_ready   (dec_ready),
        .dec_brid    (dec_brid),
        .com_valid   (com_valid),
        .com_brid    (com_brid),
        .redir_valid (redir_valid),
        .redir_brid  (redir_brid),
        .flush       (flush),
        .free_cnt    (free_cnt),
        .inflight    (inflight),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_valid   = 2'b00;
        dec_br      = 2'b00;
        com_valid   = 2'b00;
        com_brid    = '0;
        redir_valid = 1'b0;
        redir_brid  = 8'h00;
        flush       = 1'b0;
    endtask

    task automatic rst_pulse();
        idle();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();
        rst_n = 1'b0;
        #3;
        chk("rst_free", 32'(free_cnt), 16);
        chk("rst_inflight", 32'(inflight), 0);
        chk("rst_ready", 32'(dec_ready), 1);
        chk("rst_brid", 32'(dec_brid), 0);
        chk("rst_err", 32'(err), 0);
        rst_n = 1'b1;

        // Two-slot grant from empty.
        tick();
        dec_valid = 2'b11;
        dec_br    = 2'b11;
        #1;
        chk("t1_ready", 32'(dec_ready), 1);
        chk("t1_brid", 32'(dec_brid), 'h8180);
        tick();
        idle();
        #1;
        chk("t1_inflight", 32'(inflight), 2);
        chk("t1_free", 32'(free_cnt), 14);

        // Fill all 16, stall when full, then wrap to ID 0 after one commit.
        rst_pulse();
        for (int i = 0; i < 16; i++) begin
            tick();
            dec_valid = 2'b01;
            dec_br    = 2'b01;
            #1;
            chk("t2_fill_brid", 32'(dec_brid[0]), 32'('h80 | i));
        end
        tick();
        #1;
        chk("t2_full_inflight", 32'(inflight), 16);
        chk("t2_full_free", 32'(free_cnt), 0);
        chk("t2_full_ready", 32'(dec_ready), 0);
        com_valid   = 2'b01;
        com_brid[0] = 8'h80;
        tick();
        com_valid = 2'b00;
        com_brid  = '0;
        dec_valid = 2'b11;
        dec_br    = 2'b11;
        #1;
        chk("t2_one_free", 32'(free_cnt), 1);
        chk("t2_need2_ready", 32'(dec_ready), 0);
        dec_br = 2'b10;
        #1;
        chk("t2_wrap_ready", 32'(dec_ready), 1);
        chk("t2_wrap_brid", 32'(dec_brid), 'h8000);
        tick();
        idle();
        #1;
        chk("t2_refull", 32'(inflight), 16);
        chk("t2_err", 32'(err), 0);

        // Redirect inside window 3..9 at ID 5.
        rst_pulse();
        for (int i = 0; i < 5; i++) begin
            tick();
            dec_valid = 2'b11;
            dec_br    = 2'b11;
        end
        tick();
        idle();
        com_valid   = 2'b11;
        com_brid[0] = 8'h80;
        com_brid[1] = 8'h81;
        tick();
        com_valid   = 2'b01;
        com_brid[0] = 8'h82;
        com_brid[1] = 8'h00;
        tick();
        idle();
        #1;
        chk("t3_inflight7", 32'(inflight), 7);
        redir_valid = 1'b1;
        redir_brid  = 8'h85;
        dec_valid   = 2'b11;
        dec_br      = 2'b11;
        #1;
        chk("t3_redir_ready", 32'(dec_ready), 0);
        tick();
        idle();
        dec_valid = 2'b01;
        dec_br    = 2'b01;
        #1;
        chk("t3_inflight3", 32'(inflight), 3);
        chk("t3_next_brid", 32'(dec_brid[0]), 'h86);
        chk("t3_next_ready", 32'(dec_ready), 1);
        tick();
        idle();
        #1;
        chk("t3_inflight4", 32'(inflight), 4);

        // Flush with same-cycle commit of 3,4 and a redirect.
        redir_valid = 1'b1;
        redir_brid  = 8'h85;
        flush       = 1'b1;
        com_valid   = 2'b11;
        com_brid[0] = 8'h83;
        com_brid[1] = 8'h84;
        tick();
        idle();
        dec_valid = 2'b11;
        dec_br    = 2'b11;
        #1;
        chk("t4_inflight", 32'(inflight), 0);
        chk("t4_free", 32'(free_cnt), 16);
        chk("t4_err", 32'(err), 0);
        chk("t4_brid", 32'(dec_brid), 'h8685);
        tick();
        idle();
        // Redirect at 6 while committing 5,6: window drains to empty legally.
        redir_valid = 1'b1;
        redir_brid  = 8'h86;
        com_valid   = 2'b11;
        com_brid[0] = 8'h85;
        com_brid[1] = 8'h86;
        tick();
        idle();
        #1;
        chk("t4_drain_inflight", 32'(inflight), 0);
        chk("t4_drain_err", 32'(err), 0);

        // Out-of-order commit sets sticky err.
        rst_pulse();
        for (int i = 0; i < 2; i++) begin
            tick();
            dec_valid = 2'b11;
            dec_br    = 2'b11;
        end
        tick();
        idle();
        com_valid   = 2'b11;
        com_brid[0] = 8'h80;
        com_brid[1] = 8'h81;
        tick();
        com_valid   = 2'b01;
        com_brid[0] = 8'h82;
        com_brid[1] = 8'h00;
        tick();
        idle();
        #1;
        chk("t5_pre_err", 32'(err), 0);
        com_valid   = 2'b01;
        com_brid[0] = 8'h87;
        tick();
        idle();
        #1;
        chk("t5_err_set", 32'(err), 1);
        tick();
        tick();
        tick();
        chk("t5_err_sticky", 32'(err), 1);

        // Asynchronous reset between edges while allocating.
        dec_valid = 2'b11;
        dec_br    = 2'b11;
        tick();
        chk("t6_inflight2", 32'(inflight), 2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_inflight", 32'(inflight), 0);
        chk("t6_free", 32'(free_cnt), 16);
        chk("t6_err", 32'(err), 0);
        chk("t6_ready", 32'(dec_ready), 1);
        chk("t6_brid", 32'(dec_brid), 'h8180);
        rst_n = 1'b1;
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
